// File: rtl/dwt_row_sequencer_if.sv
// Token stream from the row sequencer toward the frame-memory read path.
// Each token names an even row, an odd row and a column. The read path
// fetches both rows and passes {odd, even} to the lifting unit unchanged.
interface dwt_row_sequencer_if #(
  parameter int AddrWidth = 5
);
  logic                 valid;
  logic                 ready;
  logic                 sof;
  logic                 eol;
  logic [AddrWidth-1:0] even_row;
  logic [AddrWidth-1:0] odd_row;
  logic [AddrWidth-1:0] col;

  modport master (
    input  ready,
    output valid, sof, eol, even_row, odd_row, col
  );

  modport slave (
    input  valid, sof, eol, even_row, odd_row, col,
    output ready
  );
endinterface

// File: rtl/dwt_row_sequencer.sv
// Row-pair sequencer for the vertical pass of the 9/7 lifting unit.
// For each frame it walks the pair index p from 0 to H/2+3:
//   - two leading symmetric-extension pairs,
//   - the body pairs,
//   - two trailing extension pairs.
// Within each pair it sweeps the column from 0 to W-1.
// Token fields are decoded combinationally from the pair and column
// counters. Because the counters only move on a handshake, the token
// holds stable across stalls without needing extra registers.
module dwt_row_sequencer #(
  parameter int MaximumSideSize = 32,
  parameter int SizeWidth       = $clog2(MaximumSideSize + 1),
  parameter int AddrWidth       = $clog2(MaximumSideSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [SizeWidth-1:0] width_i,
  input  logic [SizeWidth-1:0] height_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o,
  dwt_row_sequencer_if.master  m_if
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]           r_state;
  logic [SizeWidth-1:0] r_width;
  logic [SizeWidth-1:0] r_height;
  logic [SizeWidth-1:0] r_pair;
  logic [AddrWidth-1:0] r_col;
  logic                 r_done;
  logic                 r_cfgErr;

  logic                 w_valid;
  logic                 w_fire;
  logic                 w_legal;
  logic                 w_lastCol;
  logic                 w_lastPair;
  logic [SizeWidth-1:0] w_halfH;
  logic [SizeWidth-1:0] w_k;
  logic [SizeWidth-1:0] w_even;
  logic [SizeWidth-1:0] w_odd;

  assign w_valid    = (r_state == StRun);
  assign w_fire     = w_valid & m_if.ready;
  assign w_halfH    = {1'b0, r_height[SizeWidth-1:1]};
  assign w_k        = r_pair - SizeWidth'(2);
  assign w_lastCol  = (SizeWidth'(r_col) == (r_width - SizeWidth'(1)));
  assign w_lastPair = (r_pair == (w_halfH + SizeWidth'(3)));

  // A frame is legal when H is even and 6..max, and W is 1..max.
  assign w_legal = (height_i >= SizeWidth'(6)) &&
                   (height_i <= SizeWidth'(MaximumSideSize)) &&
                   !height_i[0] &&
                   (width_i >= SizeWidth'(1)) &&
                   (width_i <= SizeWidth'(MaximumSideSize));

  // Map the pair index onto its (even, odd) rows.
  // Extension pairs mirror the rows around the frame edges. All of the
  // subtractions stay non-negative because H is at least 6.
  always_comb begin
    w_even = '0;
    w_odd  = '0;
    if (r_pair == SizeWidth'(0)) begin
      w_even = SizeWidth'(4);
      w_odd  = SizeWidth'(3);
    end else if (r_pair == SizeWidth'(1)) begin
      w_even = SizeWidth'(2);
      w_odd  = SizeWidth'(1);
    end else if (r_pair <= (w_halfH + SizeWidth'(1))) begin
      w_even = {w_k[SizeWidth-2:0], 1'b0};
      w_odd  = {w_k[SizeWidth-2:0], 1'b1};
    end else if (r_pair == (w_halfH + SizeWidth'(2))) begin
      w_even = r_height - SizeWidth'(2);
      w_odd  = r_height - SizeWidth'(3);
    end else begin
      w_even = r_height - SizeWidth'(4);
      w_odd  = r_height - SizeWidth'(5);
    end
  end

  assign m_if.valid    = w_valid;
  assign m_if.sof      = w_valid && (r_pair == '0) && (r_col == '0);
  assign m_if.eol      = w_valid && w_lastCol;
  assign m_if.even_row = w_valid ? AddrWidth'(w_even) : '0;
  assign m_if.odd_row  = w_valid ? AddrWidth'(w_odd)  : '0;
  assign m_if.col      = w_valid ? r_col : '0;
  assign busy_o        = w_valid;
  assign done_o        = r_done;
  assign cfg_err_o     = r_cfgErr;

  // Control FSM.
  // IDLE accepts a start and latches the size. RUN advances column, then
  // pair, on every handshake, and returns to IDLE on the final token.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_width  <= '0;
      r_height <= '0;
      r_pair   <= '0;
      r_col    <= '0;
      r_done   <= 1'b0;
      r_cfgErr <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cfgErr <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            if (w_legal) begin
              r_state  <= StRun;
              r_width  <= width_i;
              r_height <= height_i;
              r_pair   <= '0;
              r_col    <= '0;
            end else begin
              r_cfgErr <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_fire) begin
            if (w_lastCol) begin
              r_col <= '0;
              if (w_lastPair) begin
                r_pair  <= '0;
                r_state <= StIdle;
                r_done  <= 1'b1;
              end else begin
                r_pair <= r_pair + SizeWidth'(1);
              end
            end else begin
              r_col <= r_col + AddrWidth'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dwt_row_sequencer.sv
// Directed bench for dwt_row_sequencer.
// Every token is compared against a pair table derived independently from
// the frame size, together with the busy, done and cfg_err behaviour.
module tb_dwt_row_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] width = '0;
  logic [5:0] height = '0;
  logic       busy;
  logic       done;
  logic       cfgErr;

  int checks   = 0;
  int failures = 0;

  dwt_row_sequencer_if #(.AddrWidth(5)) mIf ();

  dwt_row_sequencer #(.MaximumSideSize(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .width_i  (width),
    .height_i (height),
    .busy_o   (busy),
    .done_o   (done),
    .cfg_err_o(cfgErr),
    .m_if     (mIf.master)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one start pulse with the given size, ending 1ns after the sampling edge
  task automatic applyStimulus(input int h, input int w);
    start  = 1'b1;
    height = 6'(h);
    width  = 6'(w);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  function automatic logic [31:0] snap();
    return {12'd0, mIf.valid, busy, done, mIf.sof, mIf.eol,
            mIf.even_row, mIf.odd_row, mIf.col};
  endfunction

  // Expected token number idx of an HxW frame, in the same packing as snap()
  function automatic logic [31:0] expTok(input int h, input int w, input int idx);
    int p, c, e, o;
    logic [4:0] e5, o5, c5;
    p = idx / w;
    c = idx % w;
    if (p == 0)               begin e = 4;         o = 3;     end
    else if (p == 1)          begin e = 2;         o = 1;     end
    else if (p <= h / 2 + 1)  begin e = 2 * (p - 2); o = e + 1; end
    else if (p == h / 2 + 2)  begin e = h - 2;     o = h - 3; end
    else                      begin e = h - 4;     o = h - 5; end
    e5 = 5'(e);
    o5 = 5'(o);
    c5 = 5'(c);
    return {12'd0, 1'b1, 1'b1, 1'b0, (idx == 0), (c == w - 1), e5, o5, c5};
  endfunction

  // Run one frame: the first token is checked the cycle after start.
  // Optional behaviours: random ready, a mid-frame start pulse, or a reset abort.
  task automatic runFrame(input int h, input int w, input bit rnd, input int midStartAt, input int abortAt);
    int total, idx, cyc, busyCycles;
    bit stalled, midDone;
    logic [31:0] prevSnap;
    total      = w * (h / 2 + 4);
    idx        = 0;
    cyc        = 0;
    busyCycles = 0;
    stalled    = 1'b0;
    midDone    = 1'b0;
    prevSnap   = '0;
    mIf.ready  = 1'b1;
    applyStimulus(h, w);
    checkOutput("firstValid", {31'd0, mIf.valid}, 32'd1);
    while (idx < total && cyc < 5000) begin
      start = 1'b0;
      if (idx == abortAt) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortIdle", {30'd0, mIf.valid, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          checkOutput("abortNoDone", {31'd0, done}, 32'd0);
          @(posedge clk); #1;
        end
        return;
      end
      if (stalled) checkOutput("stallHold", snap(), prevSnap);
      checkOutput($sformatf("tok%0d", idx), snap(), expTok(h, w, idx));
      if (busy) busyCycles++;
      if (idx == midStartAt && !midDone) begin
        start   = 1'b1;
        height  = 6'd8;
        width   = 6'd4;
        midDone = 1'b1;
      end
      mIf.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = mIf.valid && !mIf.ready;
      prevSnap  = snap();
      if (mIf.valid && mIf.ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("tokenCount", 32'(idx), 32'(total));
    checkOutput("doneEnd", {29'd0, mIf.valid, busy, done}, 32'b001);
    if (!rnd) checkOutput("busyCycles", 32'(busyCycles), 32'(total));
  endtask

  task automatic checkIllegal(input string tag, input int h, input int w);
    applyStimulus(h, w);
    checkOutput({tag, "_err"}, {29'd0, cfgErr, mIf.valid, busy}, 32'b100);
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, {29'd0, cfgErr, mIf.valid, busy}, 32'b000);
  endtask

  initial begin
    mIf.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState", snap() | {29'd0, cfgErr, 2'b00}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idleAfterReset", {29'd0, busy, done, cfgErr}, 32'd0);

    $display("[TB] 16x16 frame, ready high");
    runFrame(16, 16, 1'b0, -1, -1);
    $display("[TB] back-to-back 6x1 frame started in the done cycle");
    runFrame(6, 1, 1'b0, -1, -1);
    @(posedge clk); #1;
    $display("[TB] 16x16 frame, random ready, mid-frame start");
    runFrame(16, 16, 1'b1, 20, -1);
    @(posedge clk); #1;

    $display("[TB] illegal configurations");
    checkIllegal("h4", 4, 16);
    checkIllegal("h7", 7, 16);
    checkIllegal("h34", 34, 16);
    checkIllegal("w0", 16, 0);

    $display("[TB] reset at token 40 then restart");
    runFrame(16, 16, 1'b0, -1, 40);
    runFrame(16, 16, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
